alu16_issue_ctrl: RTL

Command-side issue controller for the 16-bit ALU. It accepts operand/function commands over a valid/ready interface and buffers them in a small FIFO. Each command is presented to the combinational ALU for one stable cycle, and the ALU output is captured into a result register with its own valid/ready handshake. It sits between the instruction sequencer and `ALU16bit`, driving the `a`/`b`/`func` ports and consuming `out`.

---
 rtl/alu16_issue_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/alu16_issue_ctrl.sv
// Purpose: buffers ALU commands in a small FIFO, drives the combinational ALU one command at a time, captures each result.
// Latency: command pushed at edge N into an idle, empty block is popped at N+1; res_valid rises at N+2.
// Backpressure: cmd_ready = (count < DEPTH) from registered state; res_ready low holds the result and stalls popping.
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake carrying cmd_a, cmd_b, cmd_func
//   alu_a/alu_b/alu_func   registered drive to ALU16bit; alu_out is the ALU's combinational result
//   res_valid/res_ready    result handshake carrying res_data, res_func (and res_zero when enabled)
//   count                  FIFO occupancy, 0..DEPTH
//
// Build option: define ALU16_ISSUE_ZFLAG_EN to add the res_zero output (alu_out == 0, captured with res_data).

module alu16_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic [3:0]               cmd_func,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [3:0]               alu_func,
    input  logic [WIDTH-1:0]         alu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [3:0]               res_func,
`ifdef ALU16_ISSUE_ZFLAG_EN
    output logic                     res_zero,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // One FIFO entry: the full operand/function set for a single ALU operation.
    typedef struct packed {
        logic [3:0]       func;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] a;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    cmd_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    cmd_t           push_dat;
    cmd_t           head_dat;

    logic           cmd_push;
    logic           cmd_pop;
    logic           fifo_nonempty;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------

    // Readiness comes from the registered occupancy only, so a full FIFO
    // refuses a push even in a cycle where the head is being popped.
    assign cmd_ready     = (count < DEPTH_C);
    assign cmd_push      = cmd_valid && cmd_ready;
    assign fifo_nonempty = (count != '0);

    assign push_dat.func = cmd_func;
    assign push_dat.b    = cmd_b;
    assign push_dat.a    = cmd_a;
    assign head_dat      = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits and wrap on their own; count
    // carries the extra bit that distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (cmd_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (cmd_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({cmd_push, cmd_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------

    // HOLD only pops once the held result has been taken, so back-pressure
    // on the result side stalls the FIFO head in place.
    always_comb begin
        state_nxt = state;
        cmd_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_nonempty) begin
                    cmd_pop   = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (res_valid && res_ready) begin
                    if (fifo_nonempty) begin
                        cmd_pop   = 1'b1;
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // ALU drive and result capture
    // ------------------------------------------------------------------

    // ALU inputs only move on a pop, giving the ALU a full stable cycle in
    // EXEC before its output is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_func <= '0;
        end else if (cmd_pop) begin
            alu_a    <= head_dat.a;
            alu_b    <= head_dat.b;
            alu_func <= head_dat.func;
        end
    end

    // res_data/res_func load only in EXEC, so they are frozen for the whole
    // HOLD period regardless of what the ALU inputs do afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_func  <= '0;
        end else if (state == EXEC) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            res_func  <= alu_func;
        end else if (state == HOLD && res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef ALU16_ISSUE_ZFLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            res_zero <= 1'b0;
        end else if (state == EXEC) begin
            res_zero <= (alu_out == '0);
        end
    end
`endif

endmodule
